// File: rtl/logic_gate_pkg.sv
// Shared definitions for the pipelined bitwise gate unit: op codes and the
// per-bit gate function used by both the RTL and the reference model.
package logic_gate_pkg;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_XOR   = 3'd2;
  localparam logic [2:0] OP_NAND  = 3'd3;
  localparam logic [2:0] OP_NOR   = 3'd4;
  localparam logic [2:0] OP_XNOR  = 3'd5;
  localparam logic [2:0] OP_ANDN  = 3'd6;
  localparam logic [2:0] OP_PASSA = 3'd7;

  localparam int MAX_STAGES = 4;

  // Single-bit gate; the datapath applies it independently to every bit lane.
  function automatic logic logic_gate_f(input logic a, input logic b,
                                        input logic [2:0] op);
    case (op)
      OP_AND:  logic_gate_f = a & b;
      OP_OR:   logic_gate_f = a | b;
      OP_XOR:  logic_gate_f = a ^ b;
      OP_NAND: logic_gate_f = ~(a & b);
      OP_NOR:  logic_gate_f = ~(a | b);
      OP_XNOR: logic_gate_f = ~(a ^ b);
      OP_ANDN: logic_gate_f = a & ~b;
      default: logic_gate_f = a;
    endcase
  endfunction

endpackage

// File: rtl/logic_gate_stage.sv
// One valid/ready register slice with a pass-through ready path, so a full
// slice can accept a new beat in the same cycle its current beat leaves.
module logic_gate_stage #(
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [DW-1:0] up_data,
  output logic          dn_valid,
  input  logic          dn_ready,
  output logic [DW-1:0] dn_data
);

  assign up_ready = !dn_valid || dn_ready;

  // NOTE: sequential state uses non-blocking assignments so every slice
  // samples its neighbour's pre-edge value and beats move exactly one step.
  // NOTE: the payload is reset as well because its value is architecturally
  // visible on out_y after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) dn_data <= up_data;
    end
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// Pipelined WIDTH-bit gate unit: combinational function and flags feed a chain
// of PIPE_STAGES register slices; xfer_cnt counts completed output handshakes.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int PIPE_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_all1,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int DW = WIDTH + 2;

  if (PIPE_STAGES < 1 || PIPE_STAGES > MAX_STAGES || WIDTH < 1 || CNT_W < 1) begin : g_bad_param
    $error("logic_gate_pipe: illegal parameters WIDTH=%0d PIPE_STAGES=%0d CNT_W=%0d",
           WIDTH, PIPE_STAGES, CNT_W);
  end

  logic [WIDTH-1:0] y_c;

  // NOTE: the combinational result gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    y_c = '0;
    for (int i = 0; i < WIDTH; i++) y_c[i] = logic_gate_f(in_a[i], in_b[i], in_op);
  end

  // Index 0 is the input port side, index PIPE_STAGES is the output port side.
  logic          v [PIPE_STAGES+1];
  logic          r [PIPE_STAGES+1];
  logic [DW-1:0] d [PIPE_STAGES+1];

  assign v[0]           = in_valid;
  assign d[0]           = {y_c, (y_c == '0), (&y_c)};
  assign r[PIPE_STAGES] = out_ready;
  assign in_ready       = r[0];

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    logic_gate_stage #(.DW(DW)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (v[s]),
      .up_ready (r[s]),
      .up_data  (d[s]),
      .dn_valid (v[s+1]),
      .dn_ready (r[s+1]),
      .dn_data  (d[s+1])
    );
  end

  assign out_valid = v[PIPE_STAGES];
  assign out_y     = d[PIPE_STAGES][DW-1:2];
  assign out_zero  = d[PIPE_STAGES][1];
  assign out_all1  = d[PIPE_STAGES][0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) xfer_cnt <= '0;
    else if (out_valid && out_ready) xfer_cnt <= xfer_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed bench for logic_gate_pipe: main instance with PIPE_STAGES=2 plus
// PIPE_STAGES=1 and =4 instances for the latency reruns of the op sweep.
module tb_logic_gate_pipe;
  import logic_gate_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_a, in_b;
  logic [2:0] in_op;

  logic       in_valid, in_ready, out_valid, out_ready, out_zero, out_all1;
  logic [7:0] out_y;
  logic [3:0] xfer_cnt;

  logic       in_valid1, in_ready1, out_valid1, out_zero1, out_all11;
  logic [7:0] out_y1;
  logic [3:0] xfer_cnt1;

  logic       in_valid4, in_ready4, out_valid4, out_zero4, out_all14;
  logic [7:0] out_y4;
  logic [3:0] xfer_cnt4;

  logic       out_ready_aux;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic_gate_pipe #(.WIDTH(8), .PIPE_STAGES(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .out_zero(out_zero),
    .out_all1(out_all1), .xfer_cnt(xfer_cnt));

  logic_gate_pipe #(.WIDTH(8), .PIPE_STAGES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid1),
    .out_ready(out_ready_aux), .out_y(out_y1), .out_zero(out_zero1),
    .out_all1(out_all11), .xfer_cnt(xfer_cnt1));

  logic_gate_pipe #(.WIDTH(8), .PIPE_STAGES(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid4),
    .out_ready(out_ready_aux), .out_y(out_y4), .out_zero(out_zero4),
    .out_all1(out_all14), .xfer_cnt(xfer_cnt4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] sweep_exp [8];
    logic [7:0] bp_beats [4];
    logic [7:0] rx [$];
    int         idx;
    int         seen;

    sweep_exp = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'hA0, 8'hA5};
    bp_beats  = '{8'h11, 8'h22, 8'h33, 8'h44};

    rst_n = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0; in_valid4 = 1'b0;
    out_ready = 1'b0; out_ready_aux = 1'b1;
    in_a = '0; in_b = '0; in_op = OP_AND;

    // Reset
    repeat (3) step();
    check("rst_hold_valid", out_valid, 0);
    rst_n = 1'b1;
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_y", out_y, 8'h00);
    check("rst_xfer_cnt", xfer_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_flags", {out_zero, out_all1}, 2'b00);

    // Op sweep, back-to-back, one accept per cycle, S=2
    out_ready = 1'b1;
    in_a = 8'hA5; in_b = 8'h0F;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 8);
      in_op    = 3'(i);
      step();
      if (i >= 1 && i <= 8) begin
        check($sformatf("sweep_valid_op%0d", i - 1), out_valid, 1);
        check($sformatf("sweep_y_op%0d", i - 1), out_y, sweep_exp[i-1]);
        check($sformatf("sweep_flags_op%0d", i - 1), {out_zero, out_all1}, 2'b00);
      end
    end
    in_valid = 1'b0;
    check("sweep_drained", out_valid, 0);
    check("sweep_xfer_cnt", xfer_cnt, 8);

    // Flags
    in_a = 8'hFF; in_b = 8'hFF; in_op = OP_AND; in_valid = 1'b1;
    step();
    in_op = OP_XOR;
    step();
    in_valid = 1'b0;
    check("flag_and_y", out_y, 8'hFF);
    check("flag_and_all1_zero", {out_all1, out_zero}, 2'b10);
    step();
    check("flag_xor_y", out_y, 8'h00);
    check("flag_xor_all1_zero", {out_all1, out_zero}, 2'b01);
    step();
    check("flag_drained", out_valid, 0);
    check("flag_xfer_cnt", xfer_cnt, 10);

    // Backpressure: out_ready low, offer 4 beats
    out_ready = 1'b0;
    in_b = 8'h00; in_op = OP_PASSA;
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = (idx < 4);
      in_a     = bp_beats[idx % 4];
      if (in_valid && in_ready) begin
        step();
        idx++;
      end else begin
        step();
      end
      if (i >= 2) check($sformatf("bp_stable_y_c%0d", i), out_y, 8'h11);
    end
    check("bp_accepted", idx, 2);
    check("bp_in_ready_full", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    out_ready = 1'b1;
    #1;
    check("bp_passthrough_ready", in_ready, 1);
    for (int i = 0; i < 12 && rx.size() < 4; i++) begin
      in_valid = (idx < 4);
      in_a     = bp_beats[idx % 4];
      if (out_valid && out_ready) rx.push_back(out_y);
      if (in_valid && in_ready) idx++;
      step();
    end
    in_valid = 1'b0;
    check("bp_rx_count", rx.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("bp_rx%0d", i), (i < rx.size()) ? rx[i] : 8'hxx, bp_beats[i]);
    seen = 0;
    repeat (3) begin
      if (out_valid) seen++;
      step();
    end
    check("bp_no_duplicates", seen, 0);
    check("bp_xfer_cnt", xfer_cnt, 14);

    // Async reset with 2 beats in flight
    out_ready = 1'b0;
    in_a = 8'h5A; in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    check("ar_full_before", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid_now", out_valid, 0);
    check("ar_xfer_cnt_now", xfer_cnt, 0);
    check("ar_out_y_now", out_y, 8'h00);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (5) begin
      step();
      if (out_valid) seen++;
    end
    check("ar_no_stale", seen, 0);
    check("ar_xfer_cnt_after", xfer_cnt, 0);

    // Counter wrap: 17 transfers into a 4-bit counter
    in_a = 8'h3C; in_b = 8'h00; in_op = OP_OR; in_valid = 1'b1;
    repeat (17) step();
    in_valid = 1'b0;
    repeat (3) step();
    check("wrap_xfer_cnt", xfer_cnt, 1);

    // S=1 rerun of the op sweep: result one edge after accept
    in_a = 8'hA5; in_b = 8'h0F;
    for (int i = 0; i < 9; i++) begin
      in_valid1 = (i < 8);
      in_op     = 3'(i);
      step();
      if (i < 8) begin
        check($sformatf("s1_valid_op%0d", i), out_valid1, 1);
        check($sformatf("s1_y_op%0d", i), out_y1, sweep_exp[i]);
      end
    end
    in_valid1 = 1'b0;
    check("s1_drained", out_valid1, 0);

    // S=4 rerun of the op sweep: result three edges after the accept edge
    for (int i = 0; i < 12; i++) begin
      in_valid4 = (i < 8);
      in_op     = 3'(i);
      step();
      if (i == 2) check("s4_not_yet", out_valid4, 0);
      if (i >= 3 && i <= 10) begin
        check($sformatf("s4_valid_op%0d", i - 3), out_valid4, 1);
        check($sformatf("s4_y_op%0d", i - 3), out_y4, sweep_exp[i-3]);
      end
    end
    in_valid4 = 1'b0;
    check("s4_drained", out_valid4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
